// File: rtl/alu_md.sv
// rtl/alu_md.sv - ALU with multi-cycle multiply/divide unit and HI/LO registers
// Single-cycle ops are combinational; MULT/DIV iterate one bit per cycle on magnitudes.
module alu_md #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_SLT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       alucont,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic             start,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, sh, opb;
  logic             neg_a, neg_b, div0;
  logic             launch, last, sgn;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sgn    = ~alucont[0];
  assign launch = (state == IDLE) && start && (alucont[3:2] == 2'b10);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign mag_a  = (sgn && rd1[WIDTH-1]) ? -rd1 : rd1;
  assign mag_b  = (sgn && rd2[WIDTH-1]) ? -rd2 : rd2;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (launch) state_n = alucont[1] ? DIV : MUL;
      MUL,
      DIV:     if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // One iteration of shift-add multiply and restoring divide
  logic [WIDTH:0]     msum, shifted;
  logic [WIDTH-1:0]   mul_acc_n, mul_sh_n, div_acc_n, div_sh_n, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               ge;

  always_comb begin
    msum      = {1'b0, acc} + (sh[0] ? {1'b0, opb} : '0);
    mul_acc_n = msum[WIDTH:1];
    mul_sh_n  = {msum[0], sh[WIDTH-1:1]};
    prod      = {mul_acc_n, mul_sh_n};
    prod_fix  = (neg_a ^ neg_b) ? -prod : prod;

    shifted   = {acc, sh[WIDTH-1]};
    ge        = (shifted >= {1'b0, opb});
    div_acc_n = ge ? (shifted[WIDTH-1:0] - opb) : shifted[WIDTH-1:0];
    div_sh_n  = {sh[WIDTH-2:0], ge};
    quo_fix   = div0 ? '1 : ((neg_a ^ neg_b) ? -div_sh_n : div_sh_n);
    rem_fix   = neg_a ? -div_acc_n : div_acc_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      acc   <= '0;
      sh    <= '0;
      opb   <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      div0  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        cnt   <= '0;
        acc   <= '0;
        sh    <= mag_a;
        opb   <= mag_b;
        neg_a <= sgn & rd1[WIDTH-1];
        neg_b <= sgn & rd2[WIDTH-1];
        div0  <= (rd2 == '0);
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        if (state == MUL) begin
          acc <= mul_acc_n;
          sh  <= mul_sh_n;
        end else begin
          acc <= div_acc_n;
          sh  <= div_sh_n;
        end
        if (last) begin
          done <= 1'b1;
          if (state == MUL) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
      end
    end
  end

  always_comb begin
    res = '0;
    case (alucont)
      4'b0000: res = rd1 & rd2;
      4'b0001: res = rd1 | rd2;
      4'b0010: res = rd1 + rd2;
      4'b0011: res = {{(WIDTH-1){1'b0}}, (rd1 < rd2)};
      4'b0110: res = rd1 - rd2;
      4'b0111: res = {{(WIDTH-1){1'b0}},
                      (SIGNED_SLT ? ($signed(rd1) < $signed(rd2)) : (rd1 < rd2))};
      4'b1100: res = ~(rd1 | rd2);
      4'b1101: res = hi;
      4'b1110: res = lo;
      default: res = '0;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - self-checking bench for alu_md with a HI/LO result scoreboard
module tb_alu_md;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_MULT = 4'b1000, OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010, OP_DIVU = 4'b1011, OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MFHI = 4'b1101, OP_MFLO = 4'b1110;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  alucont;
  logic [31:0] rd1, rd2, res, hi, lo;
  logic        zero, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_v;

  alu_md #(.WIDTH(32), .SIGNED_SLT(1'b1)) dut (
    .clk(clk), .reset(reset), .alucont(alucont), .rd1(rd1), .rd2(rd2), .start(start),
    .res(res), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic comb_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eres, input logic ezero);
    alucont = op; rd1 = a; rd2 = b;
    #1;
    check({tag, ".res"}, {32'h0, res}, {32'h0, eres});
    check({tag, ".zero"}, {63'h0, zero}, {63'h0, ezero});
  endtask

  // Waits for done after a launch, counting busy cycles; leaves the bench in the done cycle
  task automatic wait_done(input string tag);
    int cycles = 0;
    int guard = 0;
    while (!done && guard < 100) begin
      if (busy) cycles++;
      guard++;
      @(negedge clk);
    end
    check({tag, ".busy_cycles"}, 64'(cycles), 64'd32);
    check({tag, ".done"}, {63'h0, done}, 64'h1);
    check({tag, ".busy_at_done"}, {63'h0, busy}, 64'h0);
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      check({tag, ".hi"}, {32'h0, hi}, {32'h0, exp_v[63:32]});
      check({tag, ".lo"}, {32'h0, lo}, {32'h0, exp_v[31:0]});
    end else begin
      check({tag, ".scoreboard_nonempty"}, 64'h0, 64'h1);
    end
  endtask

  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expv);
    sb_q.push_back(expv);
    alucont = op; rd1 = a; rd2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    int dcount;
    reset = 1'b1; start = 1'b0; alucont = OP_AND; rd1 = '0; rd2 = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", {63'h0, busy}, 64'h0);
    check("rst.done", {63'h0, done}, 64'h0);
    check("rst.hilo", {hi, lo}, 64'h0);
    reset = 1'b0;
    comb_chk("rst.mfhi", OP_MFHI, 32'h1234, 32'h5678, 32'h0, 1'b1);
    comb_chk("rst.mflo", OP_MFLO, 32'h1234, 32'h5678, 32'h0, 1'b1);

    comb_chk("sub.eq",  OP_SUB,  32'd5, 32'd5, 32'h0, 1'b1);
    comb_chk("slt",     OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    comb_chk("sltu",    OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    comb_chk("and",     OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0);
    comb_chk("or",      OP_OR,   32'hF000_0001, 32'h0000_0100, 32'hF000_0101, 1'b0);
    comb_chk("add.wrap",OP_ADD,  32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1);
    comb_chk("nor",     OP_NOR,  32'hFFFF_0000, 32'h0000_00FF, 32'h0000_FF00, 1'b0);
    comb_chk("ill4",    4'b0100, 32'h1, 32'h2, 32'h0, 1'b1);
    comb_chk("illF",    4'b1111, 32'h1, 32'h2, 32'h0, 1'b1);
    comb_chk("mult.res",OP_MULT, 32'h7, 32'h3, 32'h0, 1'b1);

    // Start with a non-md op must not launch
    alucont = OP_ADD; rd1 = 32'd1; rd2 = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start.nonmd", {63'h0, busy}, 64'h0);

    run_md("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    @(negedge clk);
    check("mult.done_pulse", {63'h0, done}, 64'h0);
    run_md("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA});
    // Back-to-back: launched in the done cycle of the previous op
    run_md("b2b.multu", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, model(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0));
    run_md("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_md("divu.zero", OP_DIVU, 32'd7, 32'd0, {32'h0000_0007, 32'hFFFF_FFFF});
    run_md("div.zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    run_md("div.ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_md("div.negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, model(OP_DIV, 32'd7, 32'hFFFF_FFFE));
    run_md("divu.big", OP_DIVU, 32'hF000_0001, 32'h0000_1234, model(OP_DIVU, 32'hF000_0001, 32'h0000_1234));
    run_md("mult.negneg", OP_MULT, 32'h8000_0000, 32'h8000_0000, model(OP_MULT, 32'h8000_0000, 32'h8000_0000));
    @(negedge clk);

    // Start held through the op, operands changed mid-flight, MFLO reads the old lo
    sb_q.push_back(model(OP_MULTU, 32'd3, 32'd5));
    alucont = OP_MULTU; rd1 = 32'd3; rd2 = 32'd5; start = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    rd1 = 32'd100; alucont = OP_MFLO;
    #1;
    check("held.mflo_busy", {32'h0, res}, {32'h0, model(OP_MULT, 32'h8000_0000, 32'h8000_0000) & 64'hFFFF_FFFF});
    alucont = OP_DIVU;
    @(negedge clk);
    dcount = 0;
    while (!done && dcount < 100) begin dcount++; @(negedge clk); end
    start = 1'b0;
    check("held.done", {63'h0, done}, 64'h1);
    exp_v = sb_q.pop_front();
    check("held.hilo", {hi, lo}, exp_v);
    @(negedge clk);
    check("held.no_relaunch", {63'h0, busy}, 64'h0);

    // Reset at cycle 10 of a DIVU aborts without a hi/lo write
    alucont = OP_DIVU; rd1 = 32'd100; rd2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy_before", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.busy", {63'h0, busy}, 64'h0);
    check("abort.hilo", {hi, lo}, 64'h0);
    dcount = 0;
    repeat (40) begin
      if (done) dcount++;
      @(negedge clk);
    end
    check("abort.no_done", 64'(dcount), 64'h0);
    comb_chk("abort.mflo", OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b1);

    // Start on the same edge as reset is ignored
    reset = 1'b1; start = 1'b1; alucont = OP_MULT; rd1 = 32'd2; rd2 = 32'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start.busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    check("rst_start.busy2", {63'h0, busy}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
